// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide with IDLE/CALC/FIN control.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow divides skip CALC and finish in cycle 1.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic              sign_a, sign_b, div_zero, div_ovf;
    logic [XLEN-1:0]   src_a, opnd, result_q, fin_val;
    logic [2*XLEN-1:0] acc, acc_step, prod;

    logic              accept, a_signed, b_signed, sign_a_in, sign_b_in;
    logic              div_zero_in, div_ovf_in;
    logic [XLEN-1:0]   abs_a_in, abs_b_in;

    // Operand decode, done combinationally so magnitudes are latched in IDLE
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         a_signed = 1'b1;
            default: ;
        endcase
        sign_a_in   = a_signed & srcA[XLEN-1];
        sign_b_in   = b_signed & srcB[XLEN-1];
        abs_a_in    = sign_a_in ? -srcA : srcA;
        abs_b_in    = sign_b_in ? -srcB : srcB;
        div_zero_in = (srcB == '0);
        div_ovf_in  = funct3[2] & ~funct3[0] & (srcA == {1'b1, {(XLEN-1){1'b0}}}) & (&srcB);
    end

    assign accept = (state == IDLE) && start && !flush;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
                if (funct3[2] && (div_zero_in || div_ovf_in)) state_nxt = FIN;
                else                                          state_nxt = CALC;
`else
                state_nxt = CALC;
`endif
            end
            CALC: if (count == CW'(XLEN-1)) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // FSM: outputs
    always_comb begin
        busy   = (state != IDLE);
        stall  = ((state == IDLE) && start) || (state == CALC);
        done   = (state == FIN) && !flush;
        result = done ? fin_val : result_q;
    end

    // One iteration: multiply adds opnd into the upper half and shifts right;
    // divide shifts left and subtracts the divisor when it fits.
    logic [XLEN:0]   mul_sum, div_up, div_diff;
    logic [2*XLEN:0] div_shift;
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
        div_shift = {acc, 1'b0};
        div_up    = div_shift[2*XLEN:XLEN];
        div_diff  = div_up - {1'b0, opnd};
        if (!op[2])             acc_step = {mul_sum, acc[XLEN-1:1]};
        else if (!div_diff[XLEN]) acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else                    acc_step = div_shift[2*XLEN-1:0];
    end

    // Sign and special-case fix-up
    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        case (op)
            3'b000:                 fin_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (div_zero)             fin_val = '1;
                else if (div_ovf)         fin_val = {1'b1, {(XLEN-1){1'b0}}};
                else if (sign_a ^ sign_b) fin_val = -acc[XLEN-1:0];
                else                      fin_val = acc[XLEN-1:0];
            end
            default: begin
                if (div_zero)     fin_val = src_a;
                else if (div_ovf) fin_val = '0;
                else if (sign_a)  fin_val = -acc[2*XLEN-1:XLEN];
                else              fin_val = acc[2*XLEN-1:XLEN];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            op       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            src_a    <= '0;
            opnd     <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                count    <= '0;
                op       <= funct3;
                sign_a   <= sign_a_in;
                sign_b   <= sign_b_in;
                div_zero <= div_zero_in;
                div_ovf  <= div_ovf_in;
                src_a    <= srcA;
                opnd     <= funct3[2] ? abs_b_in : abs_a_in;
                acc      <= {{XLEN{1'b0}}, (funct3[2] ? abs_a_in : abs_b_in)};
            end else if (state == CALC) begin
                count <= count + 1'b1;
                acc   <= acc_step;
            end
            if (done) result_q <= fin_val;
        end
    end
endmodule
